// File: rtl/tt_capture_7in.sv
// tt_capture_7in -- sequential truth-table reader for a 7-input, 1-output
// logic network.
//
// Sweeps x_o through 0..127, one value per clock, samples the network output
// f_i LAT cycles after each value is applied, and assembles the 128-bit truth
// table.  On completion it reports the onset count and whether the table
// equals the EXPECTED signature.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start_i  begin a sweep (accepted only while idle)
//   abort_i  cancel an in-progress sweep
//   f_i      output of the network being read
//   x_o      input vector for the network (x_o[0] = x0 ... x_o[6] = x6)
//   busy_o   sweep in progress (cycle after start through the done cycle)
//   done_o   one-cycle pulse when a result is complete
//   valid_o  tt_o / count_o / match_o hold a complete result
//   tt_o     captured truth table, tt_o[i] = f(x = i)
//   count_o  number of ones in tt_o
//   match_o  tt_o == EXPECTED, qualified by valid_o
//
// Control handshake: start_i and abort_i are single-cycle request levels with
// no ready return.  start_i is taken on any clock edge where the block is idle
// (busy_o low) and is ignored otherwise; abort_i takes effect on any edge
// while sweeping or draining and is ignored otherwise.  If both are high while
// idle, start wins.
//
// The FSM state register `state` is a named enum so checkers can bind to it.

module tt_capture_7in #(
  parameter int           LAT      = 0,
  parameter logic [127:0] EXPECTED = 128'hfee8eae8eae8e8a8eae8e8a8e8a8e880
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         f_i,
  output logic [6:0]   x_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         valid_o,
  output logic [127:0] tt_o,
  output logic [7:0]   count_o,
  output logic         match_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Drain runs LAT cycles; the counter compares against LAT-1.
  localparam int        PD     = (LAT > 0) ? LAT : 1;
  localparam logic [7:0] LAT_M1 = 8'(PD - 1);

  logic [7:0] drain_cnt;
  logic       cap_en;
  logic [6:0] cap_idx;
  logic       push;
  logic       flush;

  // A new index enters the capture pipeline on every sweep cycle; an abort
  // empties it so stale indices cannot leak into the next sweep.
  assign push  = (state == SWEEP) && !abort_i;
  assign flush = abort_i && ((state == SWEEP) || (state == DRAIN));

  generate
    if (LAT == 0) begin : g_direct
      // Combinational network: f_i belongs to the x_o currently applied.
      assign cap_en  = (state == SWEEP);
      assign cap_idx = x_o;
    end else begin : g_pipe
      // LAT-deep delay line of (capture enable, index): the entry leaving the
      // last stage names the truth-table bit that the present f_i belongs to.
      logic [LAT-1:0] vld;
      logic [6:0]     idx [LAT];

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          vld <= '0;
          for (int i = 0; i < LAT; i++) idx[i] <= 7'd0;
        end else begin
          vld[0] <= push;
          idx[0] <= x_o;
          for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            idx[i] <= idx[i-1];
          end
        end
      end

      assign cap_en  = vld[LAT-1];
      assign cap_idx = idx[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_o       <= 7'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      valid_o   <= 1'b0;
      tt_o      <= '0;
      count_o   <= 8'd0;
      match_o   <= 1'b0;
      drain_cnt <= 8'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= SWEEP;
            x_o     <= 7'd0;
            busy_o  <= 1'b1;
            valid_o <= 1'b0;
            match_o <= 1'b0;
            tt_o    <= '0;
            count_o <= 8'd0;
          end
        end

        SWEEP, DRAIN: begin
          if (abort_i) begin
            // Abort beats completion: no done pulse, result discarded.
            state   <= IDLE;
            x_o     <= 7'd0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            match_o <= 1'b0;
            tt_o    <= '0;
            count_o <= 8'd0;
          end else begin
            if (cap_en) begin
              tt_o[cap_idx] <= f_i;
              count_o       <= count_o + {7'd0, f_i};
            end
            if (state == SWEEP) begin
              if (x_o == 7'd127) begin
                state     <= (LAT > 0) ? DRAIN : DONE;
                drain_cnt <= 8'd0;
              end else begin
                x_o <= x_o + 7'd1;
              end
            end else begin
              // x_o stays at 127 while the last LAT samples arrive.
              if (drain_cnt == LAT_M1) begin
                state <= DONE;
              end else begin
                drain_cnt <= drain_cnt + 8'd1;
              end
            end
          end
        end

        DONE: begin
          // tt_o received its final bit on the edge that entered DONE, so the
          // comparison here sees the complete table.
          state   <= IDLE;
          done_o  <= 1'b1;
          valid_o <= 1'b1;
          match_o <= (tt_o == EXPECTED);
          busy_o  <= 1'b0;
          x_o     <= 7'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
